// File: rtl/mycpu_pkg.sv
// Shared CPU-wide constants for the register bank.
// Holds the data width, register address width, nominal clock period and
// the bit positions of the three address fields packed into rs_in.
package mycpu_pkg;

  localparam int DATAW      = 16;
  localparam int RBAW       = 4;
  localparam int CLK_PERIOD = 10;

  // rs_in layout: {write address, port-A address, port-B address}
  localparam int WADDR_MSB = 3 * RBAW - 1;
  localparam int WADDR_LSB = 2 * RBAW;
  localparam int AADDR_MSB = 2 * RBAW - 1;
  localparam int AADDR_LSB = RBAW;
  localparam int BADDR_MSB = RBAW - 1;
  localparam int BADDR_LSB = 0;

endpackage

// File: rtl/rb.sv
// rb -- general register bank, 2**RBAW registers of DATAW bits.
// One synchronous write port, two combinational read ports.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous reset, active-high (1 = clear every register)
//   d_in   : write data
//   rw_in  : write enable (1 = write d_in to the write address)
//   rs_in  : {write addr, port-A read addr, port-B read addr}
//   a_out  : port-A read data
//   b_out  : port-B read data
//
// Build option:
//   RB_WRITE_BYPASS_EN : when defined, a read of the register being written
//                        in the same cycle returns d_in instead of the
//                        stored (old) value.
module rb
  import mycpu_pkg::*;
#(
  parameter int DATAW = mycpu_pkg::DATAW,
  parameter int RBAW  = mycpu_pkg::RBAW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATAW-1:0]      d_in,
  input  logic                  rw_in,
  input  logic [3*RBAW-1:0]     rs_in,
  output logic [DATAW-1:0]      a_out,
  output logic [DATAW-1:0]      b_out
);

  localparam int NREGS = 2 ** RBAW;

  logic [DATAW-1:0] regs [NREGS];

  logic [RBAW-1:0] waddr;
  logic [RBAW-1:0] aaddr;
  logic [RBAW-1:0] baddr;

  assign waddr = rs_in[WADDR_MSB:WADDR_LSB];
  assign aaddr = rs_in[AADDR_MSB:AADDR_LSB];
  assign baddr = rs_in[BADDR_MSB:BADDR_LSB];

  // Storage: reset wins over a coincident write, so every register is
  // cleared (and therefore never X on readback once reset has been seen).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rw_in) begin
      regs[waddr] <= d_in;
    end
  end

  // Read multiplexers: zero-latency from the select inputs.
`ifdef RB_WRITE_BYPASS_EN
  always_comb begin
    a_out = regs[aaddr];
    b_out = regs[baddr];
    if (rw_in && (aaddr == waddr)) begin
      a_out = d_in;
    end
    if (rw_in && (baddr == waddr)) begin
      b_out = d_in;
    end
  end
`else
  assign a_out = regs[aaddr];
  assign b_out = regs[baddr];
`endif

endmodule

// File: tb/tb_rb.sv
// Directed self-checking bench for rb.
module tb_rb;
  import mycpu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [15:0]      d_in;
  logic             rw_in;
  logic [11:0]      rs_in;
  logic [15:0]      a_out;
  logic [15:0]      b_out;

  int n_cmp;
  int n_bad;

  rb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (d_in),
    .rw_in (rw_in),
    .rs_in (rs_in),
    .a_out (a_out),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [3:0] w, input logic [3:0] a,
                     input logic [3:0] b);
    rs_in = {w, a, b};
    #1;
  endtask

  task automatic wr(input logic [3:0] w, input logic [15:0] d);
    rw_in = 1'b1;
    d_in  = d;
    rs_in = {w, rs_in[7:0]};
    tick();
    rw_in = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_same;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    rw_in = 1'b0;
    d_in  = '0;
    rs_in = '0;
    tick();
    tick();
    rst_n = 1'b0;

    // Reset sweep: every register reads zero on both ports.
    for (int i = 0; i < 16; i++) begin
      sel(4'(i), 4'(i), 4'(15 - i));
      chk($sformatf("rst_a%0d", i), a_out, 16'h0000);
      chk($sformatf("rst_b%0d", i), b_out, 16'h0000);
    end

    // Fill every register with a distinct pattern, R0 included.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'hA5A0 + 16'(i));
    end
    for (int i = 0; i < 16; i++) begin
      sel(4'h0, 4'(i), 4'(15 - i));
      chk($sformatf("rd_a%0d", i), a_out, 16'hA5A0 + 16'(i));
      chk($sformatf("rd_b%0d", i), b_out, 16'hA5AF - 16'(i));
    end

    // Write disabled: junk data on the bus must not land anywhere.
    d_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      sel(4'(i * 5), 4'h0, 4'h0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      sel(4'h0, 4'(i), 4'(15 - i));
      chk($sformatf("hold_a%0d", i), a_out, 16'hA5A0 + 16'(i));
      chk($sformatf("hold_b%0d", i), b_out, 16'hA5AF - 16'(i));
    end

    // Same-cycle write/read of R3.
`ifdef RB_WRITE_BYPASS_EN
    exp_same = 16'h1234;
`else
    exp_same = 16'hA5A3;
`endif
    rw_in = 1'b1;
    d_in  = 16'h1234;
    sel(4'h3, 4'h3, 4'h4);
    chk("same_cyc_a", a_out, exp_same);
    chk("same_cyc_b_other", b_out, 16'hA5A4);
    tick();
    rw_in = 1'b0;
    #1;
    chk("after_wr_a", a_out, 16'h1234);

    // Reset beats a coincident write to R7.
    rst_n = 1'b1;
    rw_in = 1'b1;
    d_in  = 16'hBEEF;
    sel(4'h7, 4'h7, 4'h3);
    tick();
    rst_n = 1'b0;
    rw_in = 1'b0;
    #1;
    chk("rst_wr_r7", a_out, 16'h0000);
    chk("rst_clr_r3", b_out, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      sel(4'h0, 4'(i), 4'(i));
      chk($sformatf("rst2_a%0d", i), a_out, 16'h0000);
    end

    // First edge after reset releases accepts a write; both ports on R5.
    sel(4'h5, 4'h5, 4'h5);
    wr(4'h5, 16'h0F0F);
    #1;
    chk("dual_a5", a_out, 16'h0F0F);
    chk("dual_b5", b_out, 16'h0F0F);

    // R0 is an ordinary register.
    wr(4'h0, 16'h0001);
    sel(4'h0, 4'h0, 4'h5);
    chk("r0_a", a_out, 16'h0001);
    chk("r0_keep_r5", b_out, 16'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rb.md
RB -- requirements
Module: rb

Interface
REQ-001 SHALL have parameter DATAW, default 16, the register width in bits; it is sourced from the shared package.
REQ-002 SHALL have parameter RBAW, default 4, the register address width; the bank holds 2**RBAW = 16 registers.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; it is synchronous and active-high despite the historical name (1 = reset).
REQ-005 SHALL have port d_in, input, DATAW bits, the write data.
REQ-006 SHALL have port rw_in, input, 1 bit, the register write enable (1 = write).
REQ-007 SHALL have port rs_in, input, 3*RBAW = 12 bits, the register selects: [11:8] write address, [7:4] port-A read address, [3:0] port-B read address.
REQ-008 SHALL have port a_out, output, DATAW bits, the port-A read data.
REQ-009 SHALL have port b_out, output, DATAW bits, the port-B read data.

Function
REQ-010 SHALL implement 16 x 16-bit general registers R0..R15 with one write port and two independent read ports.
REQ-011 SHALL write d_in into register rs_in[11:8] on the rising clk edge when rw_in=1 and reset is not asserted.
REQ-012 SHALL leave all registers unchanged when rw_in=0.
REQ-013 SHALL drive a_out combinationally from register rs_in[7:4], with zero-cycle latency from a select change.
REQ-014 SHALL drive b_out combinationally from register rs_in[3:0], with zero-cycle latency from a select change.
REQ-015 SHALL make written data visible on a_out/b_out in the cycle after the write edge.
REQ-016 SHALL allow both read ports to select the same register, and both SHALL return identical data.
REQ-017 SHALL treat R0 as an ordinary writable register; it is not hardwired to zero.
REQ-018 SHALL return the old register value during a same-cycle read of the register being written, unless the bypass of REQ-024 is compiled in.
REQ-019 SHALL drive no X on a_out/b_out after reset for any select value.

Reset
REQ-020 SHALL clear all 16 registers to 16'h0000 on a rising clk edge while rst_n=1.
REQ-021 SHALL make reset take priority over a simultaneous write; the register stays 0.
REQ-022 SHALL make a_out and b_out read 16'h0000 for every select after a reset edge.
REQ-023 SHALL, on reset asserted mid-operation, lose all prior contents at that edge; writes resume on the first edge with rst_n=0.

Configuration
REQ-024 SHALL, when macro RB_WRITE_BYPASS_EN is defined, forward d_in to a_out (or b_out) whenever rw_in=1 and the port's read address equals rs_in[11:8] in the same cycle.
REQ-025 SHALL, when RB_WRITE_BYPASS_EN is undefined, include no bypass logic, so reads always reflect stored contents.

Structure
REQ-026 SHALL take DATAW, RBAW and CLK_PERIOD from package mycpu_pkg, which also holds the rs_in field-position constants (WADDR_MSB/LSB, AADDR_MSB/LSB, BADDR_MSB/LSB).
REQ-027 SHALL be a single module, rb, with storage as an array register and two read multiplexers; no sub-module is needed.

Verification
REQ-028 SHALL be verified by: reset, then sweep rs_in A/B over all 16 addresses -> a_out = b_out = 16'h0000.
REQ-029 SHALL be verified by: write 16'hA5A0+i to Ri for i=0..15, then read back with A=i, B=15-i -> a_out = 16'hA5A0+i and b_out = 16'hA5AF-i.
REQ-030 SHALL be verified by: rw_in=0, d_in=16'hFFFF for 4 cycles -> contents unchanged.
REQ-031 SHALL be verified by: same-cycle write of 16'h1234 to R3 with A=3 -> a_out shows the old value without bypass and 16'h1234 with RB_WRITE_BYPASS_EN; either way 16'h1234 next cycle.
REQ-032 SHALL be verified by: rst_n=1 concurrently with a write of 16'hBEEF to R7 -> R7 reads 16'h0000.
REQ-033 SHALL be verified by: A=B=5 after writing 16'h0F0F to R5 -> a_out = b_out = 16'h0F0F.
